// File: rtl/alu_execute_stage_pkg.sv
// Shared constants and types for the 18-bit execute stage.
// Opcode encodings match the decoder.
package alu_execute_stage_pkg;

  localparam int unsigned WIDTH = 18;
  localparam int unsigned REGW  = 4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_ADDC = 3'b111;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [REGW-1:0]  dest;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
  } entry_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDC);
  endfunction

endpackage

// File: rtl/alu_execute_stage_if.sv
// Operand-in / result-out handshake bundle of the execute stage.
// master = upstream/downstream environment, slave = the stage itself.
interface alu_execute_stage_if;
  import alu_execute_stage_pkg::*;

  logic             In_Valid;
  logic             In_Ready;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [REGW-1:0]  Dest;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Result;
  logic [REGW-1:0]  Out_Dest;
  logic             Flag_Z;
  logic             Flag_N;
  logic             Flag_C;
  logic             Flag_V;

  modport master (
    output In_Valid, Op, A, B, Dest, Out_Ready,
    input  In_Ready, Out_Valid, Result, Out_Dest, Flag_Z, Flag_N, Flag_C, Flag_V
  );

  modport slave (
    input  In_Valid, Op, A, B, Dest, Out_Ready,
    output In_Ready, Out_Valid, Result, Out_Dest, Flag_Z, Flag_N, Flag_C, Flag_V
  );

endinterface

// File: rtl/alu18_core.sv
// Combinational 18-bit ALU: ripple-carry adder shared by ADD/SUB/ADDC, plus logic ops.
module alu18_core
  import alu_execute_stage_pkg::*;
(
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             v
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             cy;

  always_comb begin
    b_eff = (op == OP_SUB) ? ~b : b;
    cy    = (op == OP_SUB) ? 1'b1 : ((op == OP_ADDC) ? cin : 1'b0);
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b_eff[i] ^ cy;
      cy     = (a[i] & b_eff[i]) | (cy & (a[i] ^ b_eff[i]));
    end

    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADDC: begin
        result = sum;
        c      = cy;
        v      = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      default: result = b;
    endcase
  end

endmodule

// File: rtl/alu_execute_stage.sv
// Registered execute stage: ALU, architectural carry flag and a 2-entry (head + skid) output buffer.
module alu_execute_stage
  import alu_execute_stage_pkg::*;
(
  input logic               C,
  input logic               Reset,
  alu_execute_stage_if.slave bus
);

  entry_t           head_q, head_d, skid_q, skid_d, new_entry;
  logic             head_valid_q, head_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q;
  logic             carry_q, carry_d;
  logic             accept, emit;
  logic [WIDTH-1:0] alu_result;
  logic             alu_c, alu_v;

  alu18_core u_core (
    .op     (bus.Op),
    .a      (bus.A),
    .b      (bus.B),
    .cin    (carry_q),
    .result (alu_result),
    .c      (alu_c),
    .v      (alu_v)
  );

  assign accept = bus.In_Valid & in_ready_q;
  assign emit   = head_valid_q & bus.Out_Ready;

  always_comb begin
    new_entry = '{result: alu_result, dest: bus.Dest, z: (alu_result == '0),
                  n: alu_result[WIDTH-1], c: alu_c, v: alu_v};
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    carry_d      = carry_q;

    if (accept && is_arith(bus.Op)) carry_d = alu_c;

    if (!head_valid_q || emit) begin
      if (skid_valid_q) begin
        head_d       = skid_q;
        head_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = new_entry;
      end else begin
        head_valid_d = accept;
        if (accept) head_d = new_entry;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = new_entry;
    end
  end

  always_ff @(posedge C) begin
    if (Reset) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      carry_q      <= 1'b0;
      // Ready is already high in the first cycle after reset; the output gate hides it during reset.
      in_ready_q   <= 1'b1;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      carry_q      <= carry_d;
      in_ready_q   <= ~skid_valid_d;
    end
  end

  assign bus.In_Ready  = in_ready_q & ~Reset;
  assign bus.Out_Valid = head_valid_q & ~Reset;
  assign bus.Result    = head_q.result;
  assign bus.Out_Dest  = head_q.dest;
  assign bus.Flag_Z    = head_q.z;
  assign bus.Flag_N    = head_q.n;
  assign bus.Flag_C    = head_q.c;
  assign bus.Flag_V    = head_q.v;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Randomized and directed bench for alu_execute_stage against a queue-based reference model.
module tb_alu_execute_stage;
  import alu_execute_stage_pkg::*;

  typedef struct {
    logic [17:0] result;
    logic [3:0]  dest;
    logic        z, n, c, v;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t q[$];
  logic model_carry;
  logic after_reset;

  alu_execute_stage_if bus ();

  alu_execute_stage dut (
    .C     (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_alu(input logic [2:0] op, input logic [17:0] a, input logic [17:0] b,
                                    input logic cin, output logic [17:0] r, output logic c,
                                    output logic v);
    int ua, ub, sa, sb, full, s;
    ua = int'(a);
    ub = int'(b);
    sa = a[17] ? ua - 262144 : ua;
    sb = b[17] ? ub - 262144 : ub;
    c = 1'b0;
    v = 1'b0;
    s = 0;
    full = 0;
    case (op)
      OP_ADD:  begin full = ua + ub;       s = sa + sb;       c = full[18]; end
      OP_ADDC: begin full = ua + ub + int'(cin); s = sa + sb + int'(cin); c = full[18]; end
      OP_SUB:  begin full = ua - ub;       s = sa - sb;       c = (ua >= ub); end
      default: ;
    endcase
    case (op)
      OP_ADD, OP_ADDC, OP_SUB: begin
        r = full[17:0];
        v = (s > 131071) || (s < -131072);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      default: r = b;
    endcase
  endfunction

  // One cycle: drive inputs at negedge, check outputs, then advance the model to the next posedge.
  task automatic step(input logic r, input logic v, input logic [2:0] op, input logic [17:0] a,
                      input logic [17:0] b, input logic [3:0] d, input logic ordy,
                      output logic acc);
    exp_t e;
    logic emit;
    @(negedge clk);
    rst = r;
    bus.In_Valid = v;
    bus.Op = op;
    bus.A = a;
    bus.B = b;
    bus.Dest = d;
    bus.Out_Ready = ordy;
    #1;
    chk("in_ready", 32'(bus.In_Ready), 32'(!r && q.size() < 2));
    chk("out_valid", 32'(bus.Out_Valid), 32'(!r && q.size() > 0));
    if (!r && q.size() > 0) begin
      chk("result", 32'(bus.Result), 32'(q[0].result));
      chk("dest", 32'(bus.Out_Dest), 32'(q[0].dest));
      chk("flags", {28'd0, bus.Flag_Z, bus.Flag_N, bus.Flag_C, bus.Flag_V},
          {28'd0, q[0].z, q[0].n, q[0].c, q[0].v});
    end else if (!r && after_reset) begin
      chk("rst_payload", {bus.Result, bus.Out_Dest, bus.Flag_Z, bus.Flag_N, bus.Flag_C, bus.Flag_V},
          32'd0);
    end
    acc  = v && !r && q.size() < 2;
    emit = ordy && !r && q.size() > 0;
    if (r) begin
      q.delete();
      model_carry = 1'b0;
      after_reset = 1'b1;
    end else begin
      if (emit) void'(q.pop_front());
      if (acc) begin
        model_alu(op, a, b, model_carry, e.result, e.c, e.v);
        e.dest = d;
        e.z = (e.result == 18'd0);
        e.n = e.result[17];
        if (op == OP_ADD || op == OP_SUB || op == OP_ADDC) model_carry = e.c;
        q.push_back(e);
        after_reset = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, 1'b0, OP_ADD, 18'd0, 18'd0, 4'd0, ordy, acc);
  endtask

  initial begin
    logic acc;
    int   n_valid;
    total = 0;
    bad = 0;
    model_carry = 1'b0;
    after_reset = 1'b0;
    rst = 1'b1;
    bus.In_Valid = 1'b0;
    bus.Op = OP_ADD;
    bus.A = '0;
    bus.B = '0;
    bus.Dest = '0;
    bus.Out_Ready = 1'b0;

    step(1'b1, 1'b1, OP_ADD, 18'd1, 18'd1, 4'd1, 1'b1, acc);
    step(1'b1, 1'b1, OP_ADD, 18'd1, 18'd1, 4'd1, 1'b1, acc);
    idle(1'b1);
    chk("reset_in_ready", 32'(bus.In_Ready), 32'd1);

    // ADD overflow into the sign bit
    step(1'b0, 1'b1, OP_ADD, 18'h1FFFF, 18'h00001, 4'd3, 1'b0, acc);
    idle(1'b0);
    chk("t1_result", 32'(bus.Result), 32'h20000);
    chk("t1_nvcz", {28'd0, bus.Flag_N, bus.Flag_V, bus.Flag_C, bus.Flag_Z}, 32'b1100);
    idle(1'b1);

    // carry out feeds ADDC
    step(1'b0, 1'b1, OP_ADD, 18'h3FFFF, 18'h00001, 4'd4, 1'b1, acc);
    step(1'b0, 1'b1, OP_ADDC, 18'd0, 18'd0, 4'd5, 1'b0, acc);
    chk("t2_zc", {30'd0, bus.Flag_Z, bus.Flag_C}, 32'b11);
    step(1'b0, 1'b0, OP_ADD, 18'd0, 18'd0, 4'd0, 1'b1, acc);
    idle(1'b0);
    chk("t2_addc", 32'(bus.Result), 32'h00001);
    chk("t2_addc_c", 32'(bus.Flag_C), 32'd0);
    idle(1'b1);

    // subtraction with and without borrow
    step(1'b0, 1'b1, OP_SUB, 18'd5, 18'd7, 4'd6, 1'b1, acc);
    step(1'b0, 1'b1, OP_SUB, 18'd7, 18'd5, 4'd7, 1'b0, acc);
    chk("t3_sub_neg", 32'(bus.Result), 32'h3FFFE);
    chk("t3_sub_nc", {30'd0, bus.Flag_N, bus.Flag_C}, 32'b10);
    step(1'b0, 1'b0, OP_ADD, 18'd0, 18'd0, 4'd0, 1'b1, acc);
    idle(1'b0);
    chk("t3_sub_pos", 32'(bus.Result), 32'h00002);
    chk("t3_sub_c", 32'(bus.Flag_C), 32'd1);
    idle(1'b1);

    // backpressure: two fill the buffer, third waits
    step(1'b0, 1'b1, OP_XOR, 18'h12345, 18'h0F0F0, 4'd8, 1'b0, acc);
    step(1'b0, 1'b1, OP_OR, 18'h00F00, 18'h30003, 4'd9, 1'b0, acc);
    step(1'b0, 1'b1, OP_NOT, 18'h0AAAA, 18'd0, 4'd10, 1'b0, acc);
    chk("t4_in_ready_low", 32'(bus.In_Ready), 32'd0);
    acc = 1'b0;
    for (int i = 0; i < 5 && !acc; i++) step(1'b0, 1'b1, OP_NOT, 18'h0AAAA, 18'd0, 4'd10, 1'b1, acc);
    chk("t4_third_accepted", 32'(acc), 32'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // streaming: no bubbles
    n_valid = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 3'($urandom_range(0, 7)), 18'($urandom), 18'($urandom), 4'(i), 1'b1, acc);
      if (bus.Out_Valid) n_valid++;
    end
    idle(1'b1);
    if (bus.Out_Valid) n_valid++;
    chk("t5_stream", 32'(n_valid), 32'd20);

    // reset with both entries full and carry set
    step(1'b0, 1'b1, OP_ADD, 18'h3FFFF, 18'h3FFFF, 4'd11, 1'b0, acc);
    step(1'b0, 1'b1, OP_AND, 18'h3FFFF, 18'h00FF0, 4'd12, 1'b0, acc);
    step(1'b1, 1'b1, OP_ADD, 18'd1, 18'd1, 4'd13, 1'b0, acc);
    idle(1'b0);
    chk("t6_out_valid", 32'(bus.Out_Valid), 32'd0);
    step(1'b0, 1'b1, OP_ADDC, 18'd1, 18'd1, 4'd14, 1'b1, acc);
    idle(1'b0);
    chk("t6_addc", 32'(bus.Result), 32'h00002);
    idle(1'b1);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0) ? 18'h3FFFF : 18'($urandom),
           ($urandom_range(0, 7) == 0) ? 18'h20000 : 18'($urandom),
           4'($urandom), ($urandom_range(0, 9) < 7), acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
